rvv_decoder: RTL and testbench

Front-end decode stage of the vector unit.
- Accepts raw 32-bit vector instruction words and the scalar operand from the scalar core.
- Executes vsetvli/vsetivli locally, owning the architectural vtype/vl state.
- Decodes arithmetic (OPIVV/OPIVX/OPIVI: vadd, vsub, vmerge, vsll, vsrl, vsra) and unit-stride vector store instructions.
- Buffers decoded micro-ops in an in-order queue that feeds the downstream issue/VFU stage.

---
 rtl/rvv_decoder_pkg.sv | 65 ++++++
 rtl/rvv_decoder_queue.sv | 60 ++++++
 rtl/rvv_decoder.sv | 178 +++++++++++++++++
 tb/tb_rvv_decoder.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rvv_decoder_pkg.sv
// Shared types and constants for the vector decode stage.
package rvv_decoder_pkg;

  localparam logic [6:0] OpcodeVec     = 7'b1010111;
  localparam logic [6:0] OpcodeStoreFP = 7'b0100111;

  localparam logic [2:0] OPIVV = 3'b000;
  localparam logic [2:0] OPMVV = 3'b010;
  localparam logic [2:0] OPIVI = 3'b011;
  localparam logic [2:0] OPIVX = 3'b100;
  localparam logic [2:0] OPCFG = 3'b111;

  localparam logic [5:0] OPVADD   = 6'b000000;
  localparam logic [5:0] OPVSUB   = 6'b000010;
  localparam logic [5:0] OPVMERGE = 6'b010111;
  localparam logic [5:0] OPVSLL   = 6'b100101;
  localparam logic [5:0] OPVSRL   = 6'b101000;
  localparam logic [5:0] OPVSRA   = 6'b101001;

  // OPCFG variants selected by insn[31:30] (0x is vsetvli)
  localparam logic [1:0] CfgVsetvl   = 2'b10;
  localparam logic [1:0] CfgVsetivli = 2'b11;

  typedef enum logic [2:0] {EW8 = 3'd0, EW16 = 3'd1, EW32 = 3'd2, EW64 = 3'd3} vsew_e;

  typedef enum logic [2:0] {
    LMUL1 = 3'b000, LMUL2 = 3'b001, LMUL4 = 3'b010, LMUL8 = 3'b011,
    LMULRSVD = 3'b100, LMULF8 = 3'b101, LMULF4 = 3'b110, LMULF2 = 3'b111
  } vlmul_e;

  // vsetvli/vsetivli layout; for vsetivli zimm[10] is insn[30] and zimm[9:0] is the real zimm
  typedef struct packed {
    logic        sel;
    logic [10:0] zimm;
    logic [4:0]  rs1;
    logic [2:0]  func3;
    logic [4:0]  rd;
    logic [6:0]  opcode;
  } vsetvli_type_t;

  typedef struct packed {
    logic [5:0]  func6;
    logic [2:0]  func3;
    logic [4:0]  vd;
    logic [4:0]  vs1;
    logic [4:0]  vs2;
    logic        vm;
    logic        is_store;
    logic [31:0] scalar;
    vsew_e       vsew;
    vlmul_e      vlmul;
    logic [31:0] vl;
  } vdec_op_t;

  // (VLEN/SEW)*LMUL; fractional LMUL codes 101/110/111 shift right by 3/2/1
  function automatic logic [31:0] vlmax(input logic [2:0] vsew, input logic [2:0] vlmul,
                                        input int unsigned vlen);
    int unsigned base;
    base = vlen >> (3 + vsew);
    if (vlmul == 3'b100) return '0;
    else if (vlmul[2]) return base >> (3'd0 - vlmul);
    else return base << vlmul[1:0];
  endfunction

endpackage

// File: rtl/rvv_decoder_queue.sv
// In-order circular FIFO of decoded vector ops.
module rvv_decoder_queue
  import rvv_decoder_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  logic     push_i,
  input  vdec_op_t data_i,
  input  logic     pop_i,
  output logic     valid_o,
  output logic     full_o,
  output vdec_op_t data_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  vdec_op_t        mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            push_eff, pop_eff;

  assign full_o   = (cnt_q == CntW'(Depth));
  assign valid_o  = (cnt_q != '0);
  assign push_eff = push_i & ~full_o;
  assign pop_eff  = pop_i & valid_o;
  assign data_o   = mem_q[rd_ptr_q];

  // Pointer and occupancy update; Depth is a power of two so pointers wrap naturally
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_eff) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop_eff)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    if (push_eff && !pop_eff)      cnt_d = cnt_q + CntW'(1);
    else if (pop_eff && !push_eff) cnt_d = cnt_q - CntW'(1);
  end

  // Control state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset; entries are only read when counted valid
  always_ff @(posedge clk_i) begin
    if (push_eff) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/rvv_decoder.sv
// Vector front-end decoder: executes vsetvli/vsetivli, decodes OPIV* arithmetic and
// unit-stride stores into a micro-op queue. Optional macro RVV_DECODER_BYPASS_EN lets a
// legal op skip an empty queue when downstream is ready.
module rvv_decoder
  import rvv_decoder_pkg::*;
#(
  parameter int unsigned QueueDepth = 4,
  parameter int unsigned VLEN       = 128,
  parameter int unsigned ELEN       = 64
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        insn_valid_i,
  output logic        insn_ready_o,
  input  logic [31:0] insn_i,
  input  logic [31:0] rs1_i,
  output logic        resp_valid_o,
  output logic        resp_illegal_o,
  output logic [31:0] resp_vl_o,
  output logic        op_valid_o,
  input  logic        op_ready_i,
  output vdec_op_t    op_o
);

  logic [6:0] opcode;
  logic [2:0] func3;
  logic [5:0] func6;
  logic       vm;
  vsetvli_type_t cfg;

  assign opcode = insn_i[6:0];
  assign func3  = insn_i[14:12];
  assign func6  = insn_i[31:26];
  assign vm     = insn_i[25];
  assign cfg    = vsetvli_type_t'(insn_i);

  logic        vill_q, vill_d, vta_q, vta_d, vma_q, vma_d;
  vsew_e       vsew_q, vsew_d;
  vlmul_e      vlmul_q, vlmul_d;
  logic [31:0] vl_q, vl_d;
  logic        resp_valid_q, resp_illegal_q;
  logic [31:0] resp_vl_q, resp_vl_d;

  logic        accept, cfg_ok, arith_ok, store_ok, illegal, push_req;
  logic        is_ivli, rsvd_nz, cfg_vill, shift_op;
  logic [2:0]  vsew_raw, vlmul_raw, frac_sh;
  logic [31:0] sew_bits, cfg_vlmax, avl, cfg_vl;
  vdec_op_t    new_op;

  logic        q_push, q_valid, q_full, bypass;
  vdec_op_t    q_data;

  assign accept       = insn_valid_i & insn_ready_o;
  assign insn_ready_o = ~q_full;

  // Classify, check legality, build the op and compute the next vtype/vl.
  // vtype/vl register at the accepting edge, so an instruction accepted the very next
  // cycle already snapshots the new configuration.
  always_comb begin
    is_ivli   = ({cfg.sel, cfg.zimm[10]} == CfgVsetivli);
    cfg_ok    = (opcode == OpcodeVec) && (func3 == OPCFG) &&
                ({cfg.sel, cfg.zimm[10]} != CfgVsetvl);
    vlmul_raw = cfg.zimm[2:0];
    vsew_raw  = cfg.zimm[5:3];
    rsvd_nz   = is_ivli ? |cfg.zimm[9:8] : |cfg.zimm[10:8];
    sew_bits  = 32'd8 << vsew_raw;
    frac_sh   = 3'd0 - vlmul_raw;
    cfg_vill  = (vlmul_raw == LMULRSVD) | vsew_raw[2] | (sew_bits > ELEN) |
                (vlmul_raw[2] & (sew_bits > (ELEN >> frac_sh))) | rsvd_nz;
    cfg_vlmax = vlmax(vsew_raw, vlmul_raw, VLEN);
    if (is_ivli)              avl = {27'd0, cfg.rs1};
    else if (cfg.rs1 != '0)   avl = rs1_i;
    else if (cfg.rd != '0)    avl = cfg_vlmax;
    else                      avl = vl_q;
    cfg_vl = cfg_vill ? '0 : ((avl < cfg_vlmax) ? avl : cfg_vlmax);

    shift_op = func6 inside {OPVSLL, OPVSRL, OPVSRA};
    arith_ok = (opcode == OpcodeVec) && (func3 != OPCFG) &&
               (func6 inside {OPVADD, OPVSUB, OPVMERGE, OPVSLL, OPVSRL, OPVSRA}) &&
               (func3 inside {OPIVV, OPIVX, OPIVI}) &&
               !((func6 == OPVSUB) && (func3 == OPIVI)) &&
               !((func6 == OPVMERGE) && vm) && !vill_q && (vl_q != '0);
    store_ok = (opcode == OpcodeStoreFP) && (func3 inside {3'b000, 3'b101, 3'b110, 3'b111});
    illegal  = !(cfg_ok || arith_ok || store_ok);
    push_req = accept && (arith_ok || store_ok);

    new_op          = '0;
    new_op.func6    = func6;
    new_op.func3    = func3;
    new_op.vd       = insn_i[11:7];
    new_op.vs1      = insn_i[19:15];
    new_op.vs2      = insn_i[24:20];
    new_op.vm       = vm;
    new_op.is_store = store_ok;
    new_op.vsew     = vsew_q;
    new_op.vlmul    = vlmul_q;
    new_op.vl       = vl_q;
    if (store_ok || (func3 == OPIVX)) new_op.scalar = rs1_i;
    else if (func3 == OPIVI) new_op.scalar = shift_op ? {27'd0, insn_i[19:15]}
                                                      : {{27{insn_i[19]}}, insn_i[19:15]};

    vill_d    = vill_q;
    vsew_d    = vsew_q;
    vlmul_d   = vlmul_q;
    vta_d     = vta_q;
    vma_d     = vma_q;
    vl_d      = vl_q;
    resp_vl_d = resp_vl_q;
    if (accept && cfg_ok) begin
      vill_d    = cfg_vill;
      vsew_d    = cfg_vill ? EW8 : vsew_e'(vsew_raw);
      vlmul_d   = cfg_vill ? LMUL1 : vlmul_e'(vlmul_raw);
      vta_d     = cfg_vill ? 1'b0 : cfg.zimm[6];
      vma_d     = cfg_vill ? 1'b0 : cfg.zimm[7];
      vl_d      = cfg_vl;
      resp_vl_d = cfg_vl;
    end
  end

  // Architectural vtype/vl and the one-cycle response register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vill_q         <= 1'b1;
      vsew_q         <= EW8;
      vlmul_q        <= LMUL1;
      vta_q          <= 1'b0;
      vma_q          <= 1'b0;
      vl_q           <= '0;
      resp_valid_q   <= 1'b0;
      resp_illegal_q <= 1'b0;
      resp_vl_q      <= '0;
    end else begin
      vill_q         <= vill_d;
      vsew_q         <= vsew_d;
      vlmul_q        <= vlmul_d;
      vta_q          <= vta_d;
      vma_q          <= vma_d;
      vl_q           <= vl_d;
      resp_valid_q   <= accept;
      resp_illegal_q <= accept & illegal;
      resp_vl_q      <= resp_vl_d;
    end
  end

  assign resp_valid_o   = resp_valid_q;
  assign resp_illegal_o = resp_illegal_q;
  assign resp_vl_o      = resp_vl_q;

`ifdef RVV_DECODER_BYPASS_EN
  assign bypass     = push_req & ~q_valid & op_ready_i;
  assign op_valid_o = q_valid | bypass;
  assign op_o       = q_valid ? q_data : new_op;
`else
  assign bypass     = 1'b0;
  assign op_valid_o = q_valid;
  assign op_o       = q_data;
`endif

  assign q_push = push_req & ~bypass;

  rvv_decoder_queue #(
    .Depth (QueueDepth)
  ) u_queue (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (q_push),
    .data_i  (new_op),
    .pop_i   (op_ready_i),
    .valid_o (q_valid),
    .full_o  (q_full),
    .data_o  (q_data)
  );

  // vta/vma are held for completeness but nothing downstream reads them yet
  logic unused_sigs;
  assign unused_sigs = ^{cfg.opcode, cfg.func3, vta_q, vma_q};

endmodule

// File: tb/tb_rvv_decoder.sv
// Bench for rvv_decoder: behavioural model plus directed vectors.
module tb_rvv_decoder;
  import rvv_decoder_pkg::*;

  localparam int unsigned QD = 4;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        insn_valid_i = 1'b0;
  logic        op_ready_i = 1'b0;
  logic [31:0] insn_i = '0;
  logic [31:0] rs1_i = '0;
  logic        insn_ready_o, resp_valid_o, resp_illegal_o, op_valid_o;
  logic [31:0] resp_vl_o;
  vdec_op_t    op_o;

  always #5 clk_i = ~clk_i;

  rvv_decoder #(
    .QueueDepth (QD),
    .VLEN       (128),
    .ELEN       (64)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .insn_valid_i   (insn_valid_i),
    .insn_ready_o   (insn_ready_o),
    .insn_i         (insn_i),
    .rs1_i          (rs1_i),
    .resp_valid_o   (resp_valid_o),
    .resp_illegal_o (resp_illegal_o),
    .resp_vl_o      (resp_vl_o),
    .op_valid_o     (op_valid_o),
    .op_ready_i     (op_ready_i),
    .op_o           (op_o)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_vill, m_sew_code, m_lmul_code;
  logic [31:0] m_vl;
  vdec_op_t    mq[$];
  bit          exp_rv, exp_ril, exp_cfg, push_valid, chk_en = 0;
  logic [31:0] exp_vl;
  vdec_op_t    push_op;
  bit          m_acc, m_pop;

  task automatic model_accept(input logic [31:0] insn, input logic [31:0] rs1);
    int f6, f3, zimm, lc, sc, sew, num, den;
    longint avl, vmax;
    bit bad, legal, shift;
    vdec_op_t op;
    f6 = int'(insn[31:26]);
    f3 = int'(insn[14:12]);
    exp_ril = 0;
    exp_cfg = 0;
    push_valid = 0;
    op = '0;
    op.func6 = insn[31:26]; op.func3 = insn[14:12]; op.vd = insn[11:7];
    op.vs1 = insn[19:15]; op.vs2 = insn[24:20]; op.vm = insn[25];
    op.vsew = vsew_e'(m_sew_code[2:0]); op.vlmul = vlmul_e'(m_lmul_code[2:0]); op.vl = m_vl;
    if (insn[6:0] == 7'h57 && f3 == 7) begin
      if (insn[31:30] == 2'b10) exp_ril = 1;
      else begin
        zimm = insn[31] ? int'(insn[29:20]) : int'(insn[30:20]);
        lc = zimm & 7;
        sc = (zimm >> 3) & 7;
        sew = 8 << sc;
        if (lc < 4) begin num = 1 << lc; den = 1; end
        else begin num = 1; den = 1 << (8 - lc); end
        bad = ((zimm >> 8) != 0) || lc == 4 || sc > 3 || sew > 64 || sew * den > 64 * num;
        if (bad) begin
          m_vill = 1; m_sew_code = 0; m_lmul_code = 0; m_vl = 0;
        end else begin
          vmax = longint'(128 * num / (sew * den));
          if (insn[31]) avl = longint'(insn[19:15]);
          else if (insn[19:15] != 0) avl = longint'(rs1);
          else if (insn[11:7] != 0) avl = vmax;
          else avl = longint'(m_vl);
          m_vl = (avl < vmax) ? 32'(avl) : 32'(vmax);
          m_vill = 0; m_sew_code = sc; m_lmul_code = lc;
        end
        exp_cfg = 1;
        exp_vl = m_vl;
      end
    end else if (insn[6:0] == 7'h57) begin
      shift = (f6 == 37 || f6 == 40 || f6 == 41);
      legal = (f6 == 0 || f6 == 2 || f6 == 23 || shift) && (f3 == 0 || f3 == 3 || f3 == 4) &&
              !(f6 == 2 && f3 == 3) && !(f6 == 23 && insn[25]) && m_vill == 0 && m_vl != 0;
      if (f3 == 4) op.scalar = rs1;
      else if (f3 == 3) op.scalar = shift ? 32'(insn[19:15]) : 32'(signed'(insn[19:15]));
      if (legal) begin push_valid = 1; push_op = op; end
      else exp_ril = 1;
    end else if (insn[6:0] == 7'h27 && (f3 == 0 || f3 >= 5)) begin
      op.is_store = 1;
      op.scalar = rs1;
      push_valid = 1;
      push_op = op;
    end else exp_ril = 1;
  endtask

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mq.delete();
      m_vill = 1; m_sew_code = 0; m_lmul_code = 0; m_vl = 0;
      exp_rv = 0; exp_ril = 0; exp_cfg = 0; exp_vl = 0; push_valid = 0;
    end else begin
      m_acc = insn_valid_i && (mq.size() < QD);
      m_pop = op_ready_i && (mq.size() != 0);
      exp_rv = m_acc;
      push_valid = 0;
      if (m_acc) model_accept(insn_i, rs1_i);
      else begin exp_ril = 0; exp_cfg = 0; end
      if (m_pop) void'(mq.pop_front());
      if (push_valid) mq.push_back(push_op);
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk_i) begin
    if (chk_en) begin
      check("insn_ready", insn_ready_o, mq.size() < QD);
      check("op_valid", op_valid_o, mq.size() != 0);
      if (mq.size() != 0) check("op_head", op_o, mq[0]);
      check("resp_valid", resp_valid_o, exp_rv);
      if (exp_rv) check("resp_illegal", resp_illegal_o, exp_ril);
      if (exp_rv && exp_cfg) check("resp_vl", resp_vl_o, exp_vl);
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [31:0] insn, input logic [31:0] rs1);
    insn_valid_i = 1'b1;
    insn_i = insn;
    rs1_i = rs1;
    @(negedge clk_i);
    insn_valid_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  localparam logic [31:0] VaddVv   = 32'h022180D7;
  localparam logic [31:0] VsetE32  = 32'h0102F0D7;
  localparam logic [31:0] VsetE8M8 = 32'h0032F0D7;

  vdec_op_t h;

  initial begin
    repeat (2) @(negedge clk_i);
    check("rst_op_valid", op_valid_o, 1'b0);
    check("rst_resp_valid", resp_valid_o, 1'b0);
    check("rst_resp_illegal", resp_illegal_o, 1'b0);
    check("rst_resp_vl", resp_vl_o, 32'd0);
    check("rst_insn_ready", insn_ready_o, 1'b1);
    rst_ni = 1'b1;
    chk_en = 1;
    @(negedge clk_i);

    send(VaddVv, 32'd0);
    check("vill_vadd_illegal", resp_illegal_o, 1'b1);
    check("vill_vadd_noop", op_valid_o, 1'b0);

    send(VsetE32, 32'd100);
    check("e32m1_vl", resp_vl_o, 32'd4);
    send(VsetE8M8, 32'd100);
    check("e8m8_vl", resp_vl_o, 32'd100);
    send(VsetE32, 32'd100);
    check("e32m1_vl_again", resp_vl_o, 32'd4);

    send(VaddVv, 32'd0);
    h = op_o;
    check("vadd_valid", op_valid_o, 1'b1);
    check("vadd_vd", h.vd, 5'd1);
    check("vadd_vs2", h.vs2, 5'd2);
    check("vadd_vs1", h.vs1, 5'd3);
    check("vadd_vm", h.vm, 1'b1);
    check("vadd_vsew", h.vsew, EW32);
    check("vadd_vl", h.vl, 32'd4);
    op_ready_i = 1'b1;
    @(negedge clk_i);
    op_ready_i = 1'b0;

    // Fill the queue, then check that a pop does not admit a same-cycle insn
    send(32'h022182D7, 32'd0);
    send(32'h0A21C357, 32'h0000_1234);
    send(32'h962FB3D7, 32'd0);
    send(32'h02056227, 32'h0000_1000);
    check("full_ready", insn_ready_o, 1'b0);
    insn_valid_i = 1'b1; insn_i = VaddVv; rs1_i = '0; op_ready_i = 1'b1;
    @(negedge clk_i);
    insn_valid_i = 1'b0; op_ready_i = 1'b0;
    check("after_pop_ready", insn_ready_o, 1'b1);
    check("full_no_resp", resp_valid_o, 1'b0);
    h = op_o;
    check("fifo_order_vd", h.vd, 5'd6);
    check("vsub_vx_scalar", h.scalar, 32'h0000_1234);
    op_ready_i = 1'b1;
    repeat (4) @(negedge clk_i);

    send(32'h562180D7, 32'd0);
    check("bad_func6", resp_illegal_o, 1'b1);
    send(32'h8032F0D7, 32'd7);
    check("vsetvl_illegal", resp_illegal_o, 1'b1);
    send(32'h01007057, 32'd0);
    check("vl_kept", resp_vl_o, 32'd4);
    send(32'h0A21B0D7, 32'd0);
    send(32'h5E21B0D7, 32'd0);
    send(32'h00000013, 32'd0);
    send(32'h0221A0D7, 32'd0);
    send(32'h5C21B0D7, 32'd0);
    send(32'h022FB0D7, 32'd0);
    send(32'hA62FB0D7, 32'd0);
    @(negedge clk_i);

    // Back-to-back vsetvli then vadd.vx
    op_ready_i = 1'b0;
    send(32'h0092F0D7, 32'hDEADBEEF);
    check("e16m2_vl", resp_vl_o, 32'd16);
    send(32'h0221C0D7, 32'hDEADBEEF);
    h = op_o;
    check("fwd_legal", resp_illegal_o, 1'b0);
    check("fwd_vl", h.vl, 32'd16);
    check("fwd_scalar", h.scalar, 32'hDEADBEEF);
    check("fwd_vsew", h.vsew, EW16);
    check("fwd_vlmul", h.vlmul, LMUL2);
    op_ready_i = 1'b1;

    send(32'hC1F2F0D7, 32'd0);
    check("e64mf2_vill_vl", resp_vl_o, 32'd0);
    send(VaddVv, 32'd0);
    check("vill_again_illegal", resp_illegal_o, 1'b1);
    send(32'hC072F0D7, 32'd0);
    check("ivli_e8mf2_vl", resp_vl_o, 32'd5);
    send(32'h02056227, 32'h0000_2000);
    send(32'h022FB0D7, 32'd0);
    @(negedge clk_i);

    // Reset in the middle of traffic
    op_ready_i = 1'b0;
    send(32'h022FB0D7, 32'd0);
    send(32'hA62FB0D7, 32'd0);
    #2;
    chk_en = 0;
    rst_ni = 1'b0;
    #1;
    check("midrst_op_valid", op_valid_o, 1'b0);
    check("midrst_ready", insn_ready_o, 1'b1);
    @(negedge clk_i);
    rst_ni = 1'b1;
    chk_en = 1;
    @(negedge clk_i);
    send(VaddVv, 32'd0);
    check("midrst_vill", resp_illegal_o, 1'b1);
    @(negedge clk_i);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
